// File: rtl/vid_in_to_axis_rgb888_if.sv
// ---------------------------------------------------------------------------
// vid_in_to_axis_rgb888_if
//
// Purpose:
//   AXI4-Stream video bus carrying RGB888 pixels out of vid_in_to_axis_rgb888.
//   tuser marks start-of-frame, tlast marks end-of-line.
//
// Signals:
//   tdata   pixel data (DATA_W bits)
//   tvalid  beat valid (master -> slave)
//   tready  downstream ready (slave -> master)
//   tuser   start of frame on the first pixel of a frame
//   tlast   end of line on the last pixel of a line
//
// Modports:
//   master  drives tdata/tvalid/tuser/tlast, samples tready
//   slave   samples tdata/tvalid/tuser/tlast, drives tready
// ---------------------------------------------------------------------------
interface vid_in_to_axis_rgb888_if #(
    parameter int DATA_W = 24
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/vid_in_to_axis_rgb888.sv
// ---------------------------------------------------------------------------
// vid_in_to_axis_rgb888
//
// Purpose:
//   Converts native parallel RGB888 video (active_video / blanking / data,
//   qualified by a pixel clock enable) into an AXI4-Stream video master.
//   A one-pixel lookahead register decides tlast, an output FIFO absorbs
//   downstream backpressure, and the block measures frame geometry and
//   reports lock and overflow status.
//
// Parameters:
//   DATA_W      pixel width (24 for RGB888)
//   FIFO_DEPTH  output FIFO entries, power of two, at least 4
//   CNT_W       width/height counter width (saturating)
//
// Ports:
//   ap_clk, ap_rst      single clock, asynchronous active-high reset
//   vid_ce              pixel clock enable; video inputs sampled only when 1
//   vid_active_video    active pixel qualifier
//   vid_hblank          horizontal blank (status only, unused)
//   vid_vblank          vertical blank
//   vid_hsync/vid_vsync sync pulses (unused)
//   vid_data            pixel data
//   m_axis              AXI4-Stream master (vid_in_to_axis_rgb888_if.master)
//   overflow            sticky, a pixel was dropped because the FIFO was full
//   clr_overflow        single-cycle pulse clearing overflow (and line_err)
//   locked              two consecutive frames with identical nonzero geometry
//   det_width           active pixels in the first line of the last frame
//   det_height          active lines in the last complete frame
//
// Configuration:
//   VID_LINE_CHECK_EN   when defined, adds a sticky line_err output that is
//                       set when any line of a frame differs in length from
//                       that frame's first line; locked is cleared for that
//                       frame. When undefined, no line_err port exists.
// ---------------------------------------------------------------------------
module vid_in_to_axis_rgb888 #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 12
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    vid_ce,
    input  logic                    vid_active_video,
    input  logic                    vid_hblank,
    input  logic                    vid_vblank,
    input  logic                    vid_hsync,
    input  logic                    vid_vsync,
    input  logic [DATA_W-1:0]       vid_data,
    vid_in_to_axis_rgb888_if.master m_axis,
    output logic                    overflow,
    input  logic                    clr_overflow,
    output logic                    locked,
    output logic [CNT_W-1:0]        det_width,
    output logic [CNT_W-1:0]        det_height
`ifdef VID_LINE_CHECK_EN
    ,
    output logic                    line_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_VBLANK,
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t            state_q, state_d;

    logic              holdValid_q, holdValid_d;
    logic              holdUser_q, holdUser_d;
    logic [DATA_W-1:0] holdData_q, holdData_d;

    logic [CNT_W-1:0]  pixCnt_q, pixCnt_d;
    logic [CNT_W-1:0]  lineCnt_q, lineCnt_d;
    logic [CNT_W-1:0]  firstW_q, firstW_d;
    logic [CNT_W-1:0]  detW_q, detW_d;
    logic [CNT_W-1:0]  detH_q, detH_d;
    logic              locked_q, locked_d;
    logic              overflow_q, overflow_d;

`ifdef VID_LINE_CHECK_EN
    logic              lineErrFrame_q, lineErrFrame_d;
    logic              lineErr_q, lineErr_d;
`endif

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]       wrPtr_q, rdPtr_q;
    logic              fifoEmpty;
    logic              fifoFull;
    logic              fifoRd;
    logic              wrEn;
    logic [EW-1:0]     wrWord;
    logic [EW-1:0]     rdWord;

    logic              activePix;
    logic              dropPix;
    logic              frameClean;

    // Blanking and sync inputs carry no information this block needs; they
    // are folded together so the ports stay documented yet unused.
    logic              unusedInputs;
    assign unusedInputs = ^{vid_hblank, vid_hsync, vid_vsync};

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // An active sample during vertical blanking is treated as blanking.
    assign activePix = vid_active_video && !vid_vblank;

    // FIFO status. Pointers carry one extra wrap bit to tell full from empty.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign rdWord    = mem_q[rdPtr_q[AW-1:0]];
    assign fifoRd    = !fifoEmpty && m_axis.tready;

    // The head entry is presented directly; outputs are forced to zero when
    // empty so that reset clears every output asynchronously.
    assign m_axis.tvalid = !fifoEmpty;
    assign m_axis.tdata  = fifoEmpty ? '0 : rdWord[DATA_W-1:0];
    assign m_axis.tlast  = !fifoEmpty && rdWord[DATA_W];
    assign m_axis.tuser  = !fifoEmpty && rdWord[DATA_W+1];

    assign overflow   = overflow_q;
    assign locked     = locked_q;
    assign det_width  = detW_q;
    assign det_height = detH_q;
`ifdef VID_LINE_CHECK_EN
    assign line_err   = lineErr_q;
`endif

    // Next-state logic. On each sample the held pixel is written to the
    // FIFO with tlast taken from whether the current sample is still active.
    // A write into a full FIFO that is not being read in the same cycle drops
    // the pixel and abandons the rest of the frame.
    always_comb begin
        state_d     = state_q;
        holdValid_d = holdValid_q;
        holdUser_d  = holdUser_q;
        holdData_d  = holdData_q;
        pixCnt_d    = pixCnt_q;
        lineCnt_d   = lineCnt_q;
        firstW_d    = firstW_q;
        detW_d      = detW_q;
        detH_d      = detH_q;
        locked_d    = locked_q;
        overflow_d  = overflow_q;
        wrEn        = 1'b0;
        wrWord      = '0;
        dropPix     = 1'b0;
        frameClean  = 1'b1;
`ifdef VID_LINE_CHECK_EN
        lineErrFrame_d = lineErrFrame_q;
        lineErr_d      = lineErr_q;
`endif

        // Clear first so that a same-cycle overflow event overrides it.
        if (clr_overflow) begin
            overflow_d = 1'b0;
`ifdef VID_LINE_CHECK_EN
            lineErr_d  = 1'b0;
`endif
        end

        if (vid_ce) begin
            if (holdValid_q) begin
                if (fifoFull && !fifoRd) begin
                    dropPix = 1'b1;
                end else begin
                    wrEn   = 1'b1;
                    wrWord = {holdUser_q, !activePix, holdData_q};
                end
            end

            if (dropPix) begin
                overflow_d  = 1'b1;
                locked_d    = 1'b0;
                holdValid_d = 1'b0;
                state_d     = WAIT_VBLANK;
            end else begin
                // End of line: the held pixel was the last one of its line.
                if (holdValid_q && !activePix) begin
                    if (lineCnt_q == '0) begin
                        firstW_d = pixCnt_q;
                    end
`ifdef VID_LINE_CHECK_EN
                    else if (pixCnt_q != firstW_q) begin
                        lineErrFrame_d = 1'b1;
                        lineErr_d      = 1'b1;
                        locked_d       = 1'b0;
                    end
`endif
                    lineCnt_d   = satInc(lineCnt_q);
                    pixCnt_d    = '0;
                    holdValid_d = 1'b0;
                end

                case (state_q)
                    WAIT_VBLANK: begin
                        if (vid_vblank) begin
                            state_d = WAIT_SOF;
                        end
                    end
                    WAIT_SOF: begin
                        if (activePix) begin
                            state_d        = ACTIVE;
                            holdValid_d    = 1'b1;
                            holdUser_d     = 1'b1;
                            holdData_d     = vid_data;
                            pixCnt_d       = CNT_W'(1);
                            lineCnt_d      = '0;
`ifdef VID_LINE_CHECK_EN
                            lineErrFrame_d = 1'b0;
`endif
                        end
                    end
                    ACTIVE: begin
                        if (vid_vblank) begin
                            // Frame finished; publish geometry if a line completed.
                            state_d = WAIT_SOF;
`ifdef VID_LINE_CHECK_EN
                            frameClean = !lineErrFrame_d;
`endif
                            if (lineCnt_d != '0) begin
                                detW_d   = firstW_d;
                                detH_d   = lineCnt_d;
                                locked_d = frameClean && (firstW_d != '0) &&
                                           (firstW_d == detW_q) &&
                                           (lineCnt_d == detH_q);
                            end
                        end else if (activePix) begin
                            holdValid_d = 1'b1;
                            holdUser_d  = 1'b0;
                            holdData_d  = vid_data;
                            pixCnt_d    = satInc(pixCnt_q);
                        end
                    end
                    default: begin
                        state_d = WAIT_VBLANK;
                    end
                endcase
            end
        end
    end

    // State and status registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= WAIT_VBLANK;
            holdValid_q <= 1'b0;
            holdUser_q  <= 1'b0;
            holdData_q  <= '0;
            pixCnt_q    <= '0;
            lineCnt_q   <= '0;
            firstW_q    <= '0;
            detW_q      <= '0;
            detH_q      <= '0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            holdValid_q <= holdValid_d;
            holdUser_q  <= holdUser_d;
            holdData_q  <= holdData_d;
            pixCnt_q    <= pixCnt_d;
            lineCnt_q   <= lineCnt_d;
            firstW_q    <= firstW_d;
            detW_q      <= detW_d;
            detH_q      <= detH_d;
            locked_q    <= locked_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef VID_LINE_CHECK_EN
    // Line-length check flags.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            lineErrFrame_q <= 1'b0;
            lineErr_q      <= 1'b0;
        end else begin
            lineErrFrame_q <= lineErrFrame_d;
            lineErr_q      <= lineErr_d;
        end
    end
`endif

    // FIFO pointers. A write at full is only issued together with a read,
    // so the slot being overwritten is the one leaving this cycle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (wrEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (fifoRd) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers and need no reset.
    always_ff @(posedge ap_clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q[AW-1:0]] <= wrWord;
        end
    end

endmodule

// File: tb/tb_vid_in_to_axis_rgb888.sv
// ---------------------------------------------------------------------------
// tb_vid_in_to_axis_rgb888
//
// Purpose:
//   Self-checking bench for vid_in_to_axis_rgb888. Frames are described as a
//   list of line lengths; the expected AXIS beats (data, SOF, EOL) and the
//   expected geometry/lock/overflow status are derived from that description
//   and compared against the DUT by a scoreboard monitor.
//
// Ports: none (top-level bench). Honours VID_LINE_CHECK_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_vid_in_to_axis_rgb888;

    localparam int DATA_W     = 24;
    localparam int FIFO_DEPTH = 32;
    localparam int CNT_W      = 12;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              user;
        logic              last;
    } beat_t;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              vid_ce;
    logic              vid_active_video;
    logic              vid_hblank;
    logic              vid_vblank;
    logic              vid_hsync;
    logic              vid_vsync;
    logic [DATA_W-1:0] vid_data;
    logic              overflow;
    logic              clr_overflow;
    logic              locked;
    logic [CNT_W-1:0]  det_width;
    logic [CNT_W-1:0]  det_height;
`ifdef VID_LINE_CHECK_EN
    logic              line_err;
`endif

    vid_in_to_axis_rgb888_if #(.DATA_W(DATA_W)) axisIf ();

    vid_in_to_axis_rgb888 #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .vid_ce          (vid_ce),
        .vid_active_video(vid_active_video),
        .vid_hblank      (vid_hblank),
        .vid_vblank      (vid_vblank),
        .vid_hsync       (vid_hsync),
        .vid_vsync       (vid_vsync),
        .vid_data        (vid_data),
        .m_axis          (axisIf),
        .overflow        (overflow),
        .clr_overflow    (clr_overflow),
        .locked          (locked),
        .det_width       (det_width),
        .det_height      (det_height)
`ifdef VID_LINE_CHECK_EN
        ,
        .line_err        (line_err)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    beat_t expQ[$];
    int    lineLens[$];
    int    total = 0;
    int    bad   = 0;
    int    readyMode = 0;
    bit    ceAlt = 1'b0;

    // Reference status model: geometry of the last published frame.
    int    mPrevW = 0;
    int    mPrevH = 0;
    bit    mLocked = 1'b0;
    bit    mOverflow = 1'b0;
    bit    mLineErr = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One sample per call; with ceAlt an idle cycle carrying garbage comes first.
    task automatic applyStimulus(input logic act, input logic vb, input logic hb,
                                 input logic [DATA_W-1:0] d);
        if (ceAlt) begin
            @(posedge ap_clk);
            #1;
            vid_ce           = 1'b0;
            vid_active_video = 1'($urandom_range(0, 1));
            vid_vblank       = 1'($urandom_range(0, 1));
            vid_hblank       = 1'($urandom_range(0, 1));
            vid_data         = DATA_W'($urandom());
        end
        @(posedge ap_clk);
        #1;
        vid_ce           = 1'b1;
        vid_active_video = act;
        vid_vblank       = vb;
        vid_hblank       = hb;
        vid_hsync        = hb;
        vid_vsync        = vb;
        vid_data         = d;
    endtask

    // Drives one frame described by lineLens (pixels, 4 hblank per line, then
    // 3 vblank). The first 'cap' pixels are expected at the output (cap<0: all).
    task automatic sendFrame(input bit incData, input int cap);
        int pushed = 0;
        int pixNum = 0;
        for (int l = 0; l < lineLens.size(); l++) begin
            for (int p = 0; p < lineLens[l]; p++) begin
                logic [DATA_W-1:0] d;
                beat_t b;
                pixNum++;
                d = incData ? DATA_W'(pixNum) : DATA_W'($urandom());
                if (cap < 0 || pushed < cap) begin
                    b.data = d;
                    b.user = (l == 0 && p == 0);
                    b.last = (p == lineLens[l] - 1);
                    expQ.push_back(b);
                    pushed++;
                end
                applyStimulus(1'b1, 1'b0, 1'b0, d);
            end
            for (int h = 0; h < 4; h++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'($urandom()));
        end
        for (int v = 0; v < 3; v++) applyStimulus(1'b0, 1'b1, 1'b0, DATA_W'($urandom()));
    endtask

    // Updates the status model for a frame that completed without overflow.
    task automatic modelFrameEnd();
        int w;
        int h;
        bit err = 1'b0;
        w = (lineLens[0] > CNT_MAX) ? CNT_MAX : lineLens[0];
        h = (lineLens.size() > CNT_MAX) ? CNT_MAX : lineLens.size();
`ifdef VID_LINE_CHECK_EN
        foreach (lineLens[i]) if (lineLens[i] != lineLens[0]) err = 1'b1;
        if (err) mLineErr = 1'b1;
`endif
        mLocked = (w != 0) && (h != 0) && (w == mPrevW) && (h == mPrevH) && !err;
        mPrevW  = w;
        mPrevH  = h;
    endtask

    task automatic checkGeometry(input string tag);
        checkOutput($sformatf("det_width_%s", tag), 32'(det_width), 32'(mPrevW));
        checkOutput($sformatf("det_height_%s", tag), 32'(det_height), 32'(mPrevH));
        checkOutput($sformatf("locked_%s", tag), 32'(locked), 32'(mLocked));
        checkOutput($sformatf("overflow_%s", tag), 32'(overflow), 32'(mOverflow));
`ifdef VID_LINE_CHECK_EN
        checkOutput($sformatf("line_err_%s", tag), 32'(line_err), 32'(mLineErr));
`endif
    endtask

    // Keeps the source in vertical blanking until every expected beat left.
    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            n++;
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput($sformatf("drain_%s", tag), 32'(expQ.size()), 32'd0);
    endtask

    task automatic setFrame8(input int lines);
        lineLens.delete();
        for (int i = 0; i < lines; i++) lineLens.push_back(8);
    endtask

    task automatic pulseClr();
        @(posedge ap_clk);
        #1;
        clr_overflow = 1'b1;
        @(posedge ap_clk);
        #1;
        clr_overflow = 1'b0;
        mOverflow = 1'b0;
        mLineErr  = 1'b0;
    endtask

    // Downstream ready generator, updated just after each rising edge.
    initial begin
        axisIf.tready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            case (readyMode)
                0:       axisIf.tready = 1'b1;
                1:       axisIf.tready = 1'($urandom_range(0, 1));
                default: axisIf.tready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: samples mid-cycle, pops an expected beat for every
    // handshake and checks that a stalled beat stays unchanged.
    initial begin
        logic          prevStall = 1'b0;
        logic [31:0]   prevWord = '0;
        beat_t         e;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_valid", 32'(axisIf.tvalid), 32'd1);
                    checkOutput("stall_beat",
                                32'({axisIf.tuser, axisIf.tlast, axisIf.tdata}), prevWord);
                end
                if (axisIf.tvalid && axisIf.tready) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_beat actual=%0h required=none",
                                 axisIf.tdata);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beat_data", 32'(axisIf.tdata), 32'(e.data));
                        checkOutput("beat_tuser", 32'(axisIf.tuser), 32'(e.user));
                        checkOutput("beat_tlast", 32'(axisIf.tlast), 32'(e.last));
                    end
                end
                prevStall = axisIf.tvalid && !axisIf.tready;
                prevWord  = 32'({axisIf.tuser, axisIf.tlast, axisIf.tdata});
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vid_ce = 1'b0; vid_active_video = 1'b0; vid_hblank = 1'b0; vid_vblank = 1'b0;
        vid_hsync = 1'b0; vid_vsync = 1'b0; vid_data = '0; clr_overflow = 1'b0;
        ap_rst = 1'b0;
        #1 ap_rst = 1'b1;
        #2;
        checkOutput("rst_tvalid", 32'(axisIf.tvalid), 32'd0);
        checkOutput("rst_tdata", 32'(axisIf.tdata), 32'd0);
        checkOutput("rst_tuser", 32'(axisIf.tuser), 32'd0);
        checkOutput("rst_tlast", 32'(axisIf.tlast), 32'd0);
        checkGeometry("reset");
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        $display("[TB] basic 8x4 frames");
        for (int v = 0; v < 3; v++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        setFrame8(4);
        sendFrame(1'b1, -1); modelFrameEnd(); checkGeometry("f1");
        sendFrame(1'b1, -1); modelFrameEnd(); checkGeometry("f2");
        waitDrain("f2");

        $display("[TB] random ready");
        readyMode = 1;
        for (int f = 0; f < 2; f++) begin
            sendFrame(1'b0, -1); modelFrameEnd(); checkGeometry("rnd_ready");
            waitDrain("rnd_ready");
        end
        readyMode = 0;

        $display("[TB] alternating clock enable");
        ceAlt = 1'b1;
        sendFrame(1'b1, -1); modelFrameEnd(); checkGeometry("ce_alt");
        ceAlt = 1'b0;
        waitDrain("ce_alt");

        $display("[TB] overflow with ready held low");
        readyMode = 2;
        setFrame8(8);
        sendFrame(1'b1, FIFO_DEPTH);
        mOverflow = 1'b1;
        mLocked   = 1'b0;
        checkGeometry("ovf");
        readyMode = 0;
        waitDrain("ovf");
        sendFrame(1'b0, -1); modelFrameEnd(); checkGeometry("after_ovf");
        waitDrain("after_ovf");
        pulseClr();
        checkGeometry("clr");

        $display("[TB] one-pixel lines and width saturation");
        lineLens.delete();
        for (int i = 0; i < 3; i++) lineLens.push_back(1);
        sendFrame(1'b0, -1); modelFrameEnd(); checkGeometry("w1");
        waitDrain("w1");
        lineLens.delete();
        lineLens.push_back(CNT_MAX + 5);
        sendFrame(1'b0, -1); modelFrameEnd(); checkGeometry("sat");
        waitDrain("sat");

        $display("[TB] reset in the middle of a frame");
        setFrame8(4);
        sendFrame(1'b0, -1); modelFrameEnd();
        sendFrame(1'b0, -1); modelFrameEnd(); checkGeometry("pre_rst");
        waitDrain("pre_rst");
        readyMode = 2;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 8; p++) applyStimulus(1'b1, 1'b0, 1'b0, DATA_W'($urandom()));
            for (int h = 0; h < 4; h++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
        end
        for (int p = 0; p < 4; p++) applyStimulus(1'b1, 1'b0, 1'b0, DATA_W'($urandom()));
        checkOutput("pre_rst_tvalid", 32'(axisIf.tvalid), 32'd1);
        ap_rst = 1'b1;
        expQ.delete();
        mPrevW = 0; mPrevH = 0; mLocked = 1'b0; mOverflow = 1'b0; mLineErr = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", 32'(axisIf.tvalid), 32'd0);
        checkOutput("mid_rst_tdata", 32'(axisIf.tdata), 32'd0);
        checkOutput("mid_rst_tuser", 32'(axisIf.tuser), 32'd0);
        checkGeometry("mid_rst");
        vid_ce = 1'b0;
        readyMode = 0;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        for (int p = 0; p < 4; p++) applyStimulus(1'b1, 1'b0, 1'b0, DATA_W'($urandom()));
        for (int h = 0; h < 4; h++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
        for (int p = 0; p < 8; p++) applyStimulus(1'b1, 1'b0, 1'b0, DATA_W'($urandom()));
        for (int h = 0; h < 4; h++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("post_rst_idle", 32'(axisIf.tvalid), 32'd0);
        for (int v = 0; v < 3; v++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        sendFrame(1'b1, -1); modelFrameEnd(); checkGeometry("post_rst1");
        sendFrame(1'b1, -1); modelFrameEnd(); checkGeometry("post_rst2");
        waitDrain("post_rst");

`ifdef VID_LINE_CHECK_EN
        $display("[TB] short line detection");
        lineLens.delete();
        lineLens.push_back(8); lineLens.push_back(8);
        lineLens.push_back(7); lineLens.push_back(8);
        sendFrame(1'b1, -1); modelFrameEnd(); checkGeometry("line_err");
        waitDrain("line_err");
        pulseClr();
        checkGeometry("line_err_clr");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
